// File: rtl/parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Received words are checked and presented on a one-entry valid/ready buffer.
module parity_rx #(
  parameter int   DATA_W = 8,
  parameter logic ODD    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit,
  input  logic              i_bit_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_par_err,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_commit;
  logic               w_last_bit;
  logic               w_buf_free;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_acc;
  logic               r_par_bad;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_par_err;
  logic               r_frame_err;
  logic               r_overrun;
  logic               r_busy;

  function automatic logic par_mismatch(input logic acc, input logic par_bit);
    return acc ^ par_bit;
  endfunction

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_buf_free = !r_valid || i_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a frame commits on the stop-bit strobe
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    if (i_bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!i_bit) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DATA: begin
          if (w_last_bit) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          w_commit    = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Deserialiser, bit counter and parity accumulator
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift   <= {DATA_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_acc     <= 1'b0;
      r_par_bad <= 1'b0;
    end else if (i_bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!i_bit) begin
            r_cnt <= {CNT_W{1'b0}};
            r_acc <= ODD;
          end
        end
        S_DATA: begin
          r_shift <= {i_bit, r_shift[DATA_W-1:1]};
          r_acc   <= r_acc ^ i_bit;
          if (!w_last_bit) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: r_par_bad <= par_mismatch(r_acc, i_bit);
        S_STOP:   r_par_bad <= r_par_bad;
        default:  r_cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Output buffer: load on commit when free, otherwise flag overrun
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data      <= {DATA_W{1'b0}};
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_commit && w_buf_free) begin
        r_data      <= r_shift;
        r_valid     <= 1'b1;
        r_par_err   <= r_par_bad;
        r_frame_err <= ~i_bit;
      end else if (w_commit) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_par_err   = r_par_err;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: an even-parity instance and an odd-parity instance.
module tb_parity_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_s;
  logic       en;
  logic       sel;
  logic       ready;
  logic       en0;
  logic       en1;
  logic [7:0] data0;
  logic       valid0, perr0, ferr0, ovr0, busy0;
  logic [7:0] data1;
  logic       valid1, perr1, ferr1, ovr1, busy1;
  int         n_checks;
  int         n_fail;

  assign en0 = en & ~sel;
  assign en1 = en & sel;

  parity_rx #(.DATA_W(8), .ODD(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_s), .i_bit_en(en0),
    .o_data(data0), .o_valid(valid0), .i_ready(ready),
    .o_par_err(perr0), .o_frame_err(ferr0), .o_overrun(ovr0), .o_busy(busy0)
  );

  parity_rx #(.DATA_W(8), .ODD(1'b1)) u_dut_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit_s), .i_bit_en(en1),
    .o_data(data1), .o_valid(valid1), .i_ready(ready),
    .o_par_err(perr1), .o_frame_err(ferr1), .o_overrun(ovr1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe, preceded by gap-1 idle cycles in which the line toggles.
  task automatic send_bit(input logic b, input int gap);
    for (int g = 1; g < gap; g++) begin
      en    = 1'b0;
      bit_s = ~bit_s;
      tick();
    end
    en    = 1'b1;
    bit_s = b;
    tick();
    en    = 1'b0;
  endtask

  // Start bit, data LSB first, parity bit (no stop bit).
  task automatic send_body(input logic [7:0] d, input logic par, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(par, gap);
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bit_s    = 1'b1;
    en       = 1'b0;
    sel      = 1'b0;
    ready    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_data", {24'h0, data0}, 32'h0);
    check("rst_valid", {31'h0, valid0}, 32'h0);
    check("rst_perr", {31'h0, perr0}, 32'h0);
    check("rst_ferr", {31'h0, ferr0}, 32'h0);
    check("rst_ovr", {31'h0, ovr0}, 32'h0);
    check("rst_busy", {31'h0, busy0}, 32'h0);

    // Clean frame 0xA5 (four ones, even parity bit 0)
    send_body(8'hA5, 1'b0, 1);
    check("a5_busy_mid", {31'h0, busy0}, 32'h1);
    send_bit(1'b1, 1);
    check("a5_valid", {31'h0, valid0}, 32'h1);
    check("a5_data", {24'h0, data0}, 32'hA5);
    check("a5_perr", {31'h0, perr0}, 32'h0);
    check("a5_ferr", {31'h0, ferr0}, 32'h0);
    check("a5_busy_end", {31'h0, busy0}, 32'h0);
    consume();
    check("a5_taken", {31'h0, valid0}, 32'h0);

    // 0x07 has three ones: parity 0 is wrong
    send_body(8'h07, 1'b0, 1);
    send_bit(1'b1, 1);
    check("07_data", {24'h0, data0}, 32'h07);
    check("07_perr", {31'h0, perr0}, 32'h1);
    check("07_ferr", {31'h0, ferr0}, 32'h0);
    consume();

    // 0x3C good parity, stop bit 0; the 0 stop must not restart a frame
    send_body(8'h3C, 1'b0, 1);
    send_bit(1'b0, 1);
    check("3c_data", {24'h0, data0}, 32'h3C);
    check("3c_ferr", {31'h0, ferr0}, 32'h1);
    check("3c_perr", {31'h0, perr0}, 32'h0);
    check("3c_busy", {31'h0, busy0}, 32'h0);
    consume();

    // Overrun: 0x11 held, then 0x3C arrives and is dropped
    send_body(8'h11, 1'b0, 1);
    send_bit(1'b1, 1);
    check("ovr_hold_valid", {31'h0, valid0}, 32'h1);
    send_body(8'h3C, 1'b0, 1);
    check("ovr_pre", {31'h0, ovr0}, 32'h0);
    send_bit(1'b1, 1);
    check("ovr_pulse", {31'h0, ovr0}, 32'h1);
    check("ovr_data", {24'h0, data0}, 32'h11);
    check("ovr_valid", {31'h0, valid0}, 32'h1);
    tick();
    check("ovr_one_cycle", {31'h0, ovr0}, 32'h0);
    check("ovr_data_held", {24'h0, data0}, 32'h11);
    consume();
    check("ovr_consumed", {31'h0, valid0}, 32'h0);
    tick();
    tick();
    check("ovr_no_3c", {31'h0, valid0}, 32'h0);

    // Same-edge accept of 0x11 and commit of 0x22
    send_body(8'h11, 1'b0, 1);
    send_bit(1'b1, 1);
    send_body(8'h22, 1'b0, 1);
    ready = 1'b1;
    send_bit(1'b1, 1);
    ready = 1'b0;
    check("same_valid", {31'h0, valid0}, 32'h1);
    check("same_data", {24'h0, data0}, 32'h22);
    check("same_ovr", {31'h0, ovr0}, 32'h0);
    tick();
    check("same_held", {24'h0, data0}, 32'h22);
    consume();

    // Reset mid-frame, then a clean 0x81
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    check("mid_busy", {31'h0, busy0}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", {31'h0, busy0}, 32'h0);
    check("mid_rst_data", {24'h0, data0}, 32'h0);
    check("mid_rst_valid", {31'h0, valid0}, 32'h0);
    send_body(8'h81, 1'b0, 1);
    send_bit(1'b1, 1);
    check("81_data", {24'h0, data0}, 32'h81);
    check("81_errs", {30'h0, perr0, ferr0}, 32'h0);
    consume();

    // Sparse strobes every third cycle
    send_body(8'h5A, 1'b0, 3);
    send_bit(1'b1, 3);
    check("5a_valid", {31'h0, valid0}, 32'h1);
    check("5a_data", {24'h0, data0}, 32'h5A);
    check("5a_errs", {30'h0, perr0, ferr0}, 32'h0);
    consume();

    // Odd-parity instance
    sel   = 1'b1;
    bit_s = 1'b1;
    tick();
    send_body(8'h00, 1'b1, 1);
    send_bit(1'b1, 1);
    check("odd_ok_valid", {31'h0, valid1}, 32'h1);
    check("odd_ok_perr", {31'h0, perr1}, 32'h0);
    consume();
    send_body(8'h00, 1'b0, 1);
    send_bit(1'b1, 1);
    check("odd_bad_valid", {31'h0, valid1}, 32'h1);
    check("odd_bad_perr", {31'h0, perr1}, 32'h1);
    check("odd_bad_data", {24'h0, data1}, 32'h00);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_rx.md
Name: parity_rx

Overview:
- Serial frame receiver and checker; the receive end of the parity-protected serial link whose transmit side generates the parity bit by XOR reduction.
- Frame format: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1). The line idles high.
- Deserialises each frame, checks parity and stop bit, and presents the word with error flags on a one-entry valid/ready output buffer.

Parameters:
- DATA_W, 8, number of data bits per frame (2..32).
- ODD, 0, parity sense: 0 = even parity (XOR of data and parity bit is 0), 1 = odd parity (XOR is 1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_bit  in  1  serial line; idles high.
- i_bit_en  in  1  bit-sample strobe; i_bit is sampled only in cycles where i_bit_en=1.
- o_data  out  DATA_W  received word; bit 0 is the first data bit received.
- o_valid  out  1  o_data and the error flags are valid.
- i_ready  in  1  consumer accepts the word when o_valid=1 and i_ready=1.
- o_par_err  out  1  parity mismatch for the word in o_data.
- o_frame_err  out  1  stop bit was sampled as 0 for the word in o_data.
- o_overrun  out  1  one-cycle pulse: a completed frame was dropped because the buffer was full.
- o_busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - FSM goes to IDLE; the shift register, bit counter and parity accumulator clear.
  - All outputs go to 0: o_data, o_valid, o_par_err, o_frame_err, o_overrun, o_busy.
  - A partially received frame is discarded; a word held in the buffer is lost.
- Cycles with i_bit_en=0 change no FSM or datapath state; i_bit is ignored.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with i_bit=0 -> DATA; counter=0; accumulator=ODD. On a strobe with i_bit=1, stay in IDLE.
  - DATA: each strobe shifts i_bit in at the MSB and shifts right, so the first bit ends up in bit 0. Accumulator ^= i_bit; counter++. The strobe with counter==DATA_W-1 moves to PARITY.
  - PARITY: on a strobe, record par_bad = accumulator ^ i_bit, then -> STOP.
  - STOP: on a strobe, record stop_bad = ~i_bit, commit the frame (below), then -> IDLE. A stop bit of 0 is not treated as a new start bit.
- Commit, on the stop-bit strobe edge:
  - The buffer is free if o_valid=0, or if o_valid=1 and i_ready=1 in the same cycle.
  - Buffer free: load o_data, set o_par_err=par_bad and o_frame_err=stop_bad, set o_valid=1.
  - Buffer not free: drop the frame, pulse o_overrun=1 for exactly one cycle, and leave o_data, o_valid and the flags unchanged.
- Latency: o_valid rises on the clock edge that samples the stop bit and is visible in the following cycle.
- Handshake:
  - With o_valid=1 and i_ready=1 at an edge, o_valid clears at that edge unless a commit loads a new word in the same edge; in that case o_valid stays 1 with the new contents.
  - o_data and the flags are held stable while o_valid=1 and i_ready=0.
- Errored frames are still delivered, with their flags set; the flags are meaningful only while o_valid=1.
- o_busy = (state != IDLE), registered, so it is high from the cycle after the start-bit strobe until the cycle after the stop-bit strobe.
- Minimum frame length is DATA_W+3 strobes. Back-to-back frames are allowed: the strobe after the stop bit can be the next start bit.
- Widths: the counter is $clog2(DATA_W) bits wide. There is no wrap-around other than the counter resetting on the start bit.

Test Plan (DATA_W=8 unless stated; a strobe every cycle unless stated):
- Clean frame: start, 0xA5 LSB first, parity 0, stop 1 -> one cycle after the stop strobe, o_valid=1, o_data=0xA5, o_par_err=0, o_frame_err=0; with i_ready=1, o_valid=0 on the next cycle.
- Bad parity and bad stop: 0x07 with parity 0 and stop 1 -> o_data=0x07, o_par_err=1. Then 0x3C with parity 0 and stop 0 -> o_frame_err=1, o_par_err=0.
- Overrun: 0x11 received and held with i_ready=0, then a full 0x3C frame -> o_overrun high for one cycle, o_data stays 0x11. Raise i_ready -> 0x11 is consumed and no 0x3C word appears.
- Same-edge accept and commit: i_ready=1 in the stop-strobe cycle of 0x22 while 0x11 is held -> 0x11 is accepted, o_valid stays 1, o_data=0x22, no o_overrun.
- Reset mid-frame: after a start bit and 4 data bits, i_rst_n=0 for 1 cycle -> o_busy=0 and all outputs 0. A following clean 0x81 frame -> o_data=0x81 with no errors.
- Sparse strobes and odd parity: strobe every 3rd cycle, i_bit toggled in non-strobe cycles, frame 0x5A with parity 0 -> o_data=0x5A, no errors. Instance with ODD=1: frame 0x00 with parity 1 -> o_par_err=0; the same frame with parity 0 -> o_par_err=1.
